// File: rtl/game_pkg.sv
// Shared definitions for the game-status LED path: mode encodings, status decode
// and channel masks used to build the default colours.
package game_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_SOLID  = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BREATH = 2'd3
    } mode_e;

    // Channel on/off masks ordered {red, green, blue}; expanded to R bits at the top.
    localparam logic [2:0] RGB_RED    = 3'b100;
    localparam logic [2:0] RGB_GREEN  = 3'b010;
    localparam logic [2:0] RGB_BLUE   = 3'b001;
    localparam logic [2:0] RGB_YELLOW = 3'b110;

    function automatic mode_e decode_mode(input logic [3:0] win,
                                          input logic [3:0] tie,
                                          input logic [1:0] player);
        mode_e m;
        if (win != 4'd0) begin
            m = MODE_BLINK;
        end else if (tie != 4'd0) begin
            m = MODE_BREATH;
        end else if (player == 2'd1 || player == 2'd2) begin
            m = MODE_SOLID;
        end else begin
            m = MODE_OFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: duty is captured only on the frame tick so a frame is
// never cut short or stretched, and the output is registered.
module pwm_channel #(
    parameter int R = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [R-1:0] cnt,
    input  logic         frame_tick,
    input  logic [R-1:0] duty_target,
    output logic         led
);

    logic [R-1:0] duty_q;
    logic         led_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            if (frame_tick) begin
                duty_q <= duty_target;
            end
            // Uses the duty in force for the current count, so the new duty starts at cnt == 0.
            led_q <= (cnt < duty_q);
        end
    end

    assign led = led_q;

endmodule

// File: rtl/rgb_status_pwm.sv
// Game-status RGB LED controller: decodes win/tie/player into a display mode and
// drives three frame-synchronous PWM channels (solid, blink and breathing effects).
module rgb_status_pwm
    import game_pkg::*;
#(
    parameter int           R         = 8,
    parameter logic [3*R-1:0] P1_RGB  = {{R{RGB_BLUE[2]}},   {R{RGB_BLUE[1]}},   {R{RGB_BLUE[0]}}},
    parameter logic [3*R-1:0] P2_RGB  = {{R{RGB_RED[2]}},    {R{RGB_RED[1]}},    {R{RGB_RED[0]}}},
    parameter logic [3*R-1:0] WIN_RGB = {{R{RGB_GREEN[2]}},  {R{RGB_GREEN[1]}},  {R{RGB_GREEN[0]}}},
    parameter logic [3*R-1:0] TIE_RGB = {{R{RGB_YELLOW[2]}}, {R{RGB_YELLOW[1]}}, {R{RGB_YELLOW[0]}}},
    parameter int           BLINK_DIV = 64,
    parameter int           FADE_DIV  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] win_state,
    input  logic [3:0] tie_state,
    input  logic [1:0] player_sel,
    output logic       red_LED,
    output logic       green_LED,
    output logic       blue_LED,
    output logic [1:0] mode,
    output logic       frame_tick
);

    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int FW = $clog2(FADE_DIV + 1);
    localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_DIV - 1);
    localparam logic [FW-1:0] FADE_RELOAD  = FW'(FADE_DIV - 1);
    localparam logic [R-1:0]  LEVEL_MAX    = '1;

    logic [R-1:0]  cnt_q;
    mode_e         mode_q, mode_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [FW-1:0] fade_cnt_q, fade_cnt_d;
    logic [R-1:0]  level_q, level_d;
    logic          dir_down_q, dir_down_d;

    logic          tick_w;
    logic          entering_w;
    logic [R-1:0]  duty_tgt [3];
    logic [2:0]    led_w;

    assign tick_w     = (cnt_q == LEVEL_MAX);
    assign mode_d     = decode_mode(win_state, tie_state, player_sel);
    assign entering_w = (mode_d != mode_q) &&
                        ((mode_d == MODE_BLINK) || (mode_d == MODE_BREATH));

    // Effect timers are down-counters stepped by frame ticks; a fresh entry into an
    // animated mode restarts the animation from its visible "on"/dark-start point.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        fade_cnt_d  = fade_cnt_q;
        level_d     = level_q;
        dir_down_d  = dir_down_q;
        if (entering_w) begin
            blink_cnt_d = BLINK_RELOAD;
            phase_d     = 1'b1;
            fade_cnt_d  = FADE_RELOAD;
            level_d     = '0;
            dir_down_d  = 1'b0;
        end else if (tick_w) begin
            if (blink_cnt_q == '0) begin
                blink_cnt_d = BLINK_RELOAD;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q - 1'b1;
            end
            if (fade_cnt_q == '0) begin
                fade_cnt_d = FADE_RELOAD;
                if (!dir_down_q) begin
                    if (level_q == LEVEL_MAX) begin
                        dir_down_d = 1'b1;
                        level_d    = level_q - 1'b1;
                    end else begin
                        level_d    = level_q + 1'b1;
                    end
                end else begin
                    if (level_q == '0) begin
                        dir_down_d = 1'b0;
                        level_d    = level_q + 1'b1;
                    end else begin
                        level_d    = level_q - 1'b1;
                    end
                end
            end else begin
                fade_cnt_d = fade_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            mode_q      <= MODE_OFF;
            blink_cnt_q <= BLINK_RELOAD;
            phase_q     <= 1'b1;
            fade_cnt_q  <= FADE_RELOAD;
            level_q     <= '0;
            dir_down_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_q + 1'b1;
            mode_q      <= mode_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            fade_cnt_q  <= fade_cnt_d;
            level_q     <= level_d;
            dir_down_q  <= dir_down_d;
        end
    end

    // Channel index 0 = blue, 1 = green, 2 = red, matching the {red,green,blue} packing.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            duty_tgt[c] = '0;
            case (mode_q)
                MODE_SOLID: begin
                    if (player_sel == 2'd2) begin
                        duty_tgt[c] = P2_RGB[c*R +: R];
                    end else begin
                        duty_tgt[c] = P1_RGB[c*R +: R];
                    end
                end
                MODE_BLINK: begin
                    if (phase_q) begin
                        duty_tgt[c] = WIN_RGB[c*R +: R];
                    end
                end
                MODE_BREATH: begin
                    duty_tgt[c] = R'(((2*R)'(TIE_RGB[c*R +: R]) * (2*R)'(level_q)) >> R);
                end
                default: duty_tgt[c] = '0;
            endcase
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_chan
        pwm_channel #(.R(R)) u_chan (
            .clk         (clk),
            .reset       (reset),
            .cnt         (cnt_q),
            .frame_tick  (tick_w),
            .duty_target (duty_tgt[g]),
            .led         (led_w[g])
        );
    end

    assign blue_LED   = led_w[0];
    assign green_LED  = led_w[1];
    assign red_LED    = led_w[2];
    assign mode       = mode_q;
    assign frame_tick = tick_w;

endmodule

// File: tb/tb_rgb_status_pwm.sv
// Directed bench for rgb_status_pwm with R=4, BLINK_DIV=2, FADE_DIV=1 (16-clk frames);
// per-frame LED high counts are compared with hand-computed values.
module tb_rgb_status_pwm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] win_state = 4'd0;
    logic [3:0] tie_state = 4'd0;
    logic [1:0] player_sel = 2'd0;
    logic       red_LED, green_LED, blue_LED;
    logic [1:0] mode;
    logic       frame_tick;

    int n_chk  = 0;
    int n_pass = 0;
    int r_hi [32];
    int g_hi [32];
    int b_hi [32];
    int first_tick;

    // Breathing duty per frame: level 0,1,..,15,14,..,0,1 -> (level*15)>>4.
    int exp_breath [32] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14,
                            13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
    int exp_blink [6] = '{15, 15, 0, 0, 15, 15};

    rgb_status_pwm #(.R(4), .BLINK_DIV(2), .FADE_DIV(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .win_state  (win_state),
        .tie_state  (tie_state),
        .player_sel (player_sel),
        .red_LED    (red_LED),
        .green_LED  (green_LED),
        .blue_LED   (blue_LED),
        .mode       (mode),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) found = 1'b1;
        end
        check_val("tick_seen", 32'(found), 32'd1);
    endtask

    // Leaves the bench at cnt == 1 of a frame so an input change lands well before the next tick.
    task automatic to_mid_frame();
        wait_tick();
        repeat (2) @(negedge clk);
    endtask

    // Counts LED high cycles for nf consecutive frames starting at the next tick;
    // optionally switches player_sel after global sample index sw_idx.
    task automatic measure(input int nf, input int sw_idx, input logic [1:0] sw_player);
        wait_tick();
        @(negedge clk);
        for (int f = 0; f < nf; f++) begin
            r_hi[f] = 0;
            g_hi[f] = 0;
            b_hi[f] = 0;
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                if (red_LED === 1'b1)   r_hi[f]++;
                if (green_LED === 1'b1) g_hi[f]++;
                if (blue_LED === 1'b1)  b_hi[f]++;
                if (f * 16 + j == sw_idx) player_sel = sw_player;
            end
        end
    endtask

    initial begin
        // Reset held 3 clk
        repeat (3) @(negedge clk);
        check_val("rst_mode", 32'(mode), 32'd0);
        check_val("rst_leds", 32'({red_LED, green_LED, blue_LED}), 32'd0);
        check_val("rst_tick", 32'(frame_tick), 32'd0);
        reset = 1'b0;
        first_tick = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1 && first_tick == 0) first_tick = k;
        end
        check_val("first_tick", 32'(first_tick), 32'd15);
        check_val("idle_mode", 32'(mode), 32'd0);

        // Player 1 solid blue
        to_mid_frame();
        player_sel = 2'd1;
        @(negedge clk);
        check_val("p1_mode", 32'(mode), 32'd1);
        measure(2, -1, 2'd0);
        for (int f = 0; f < 2; f++) begin
            check_val("p1_blue", 32'(b_hi[f]), 32'd15);
            check_val("p1_red", 32'(r_hi[f]), 32'd0);
            check_val("p1_green", 32'(g_hi[f]), 32'd0);
        end

        // Player 2 solid red
        to_mid_frame();
        player_sel = 2'd2;
        @(negedge clk);
        check_val("p2_mode", 32'(mode), 32'd1);
        measure(1, -1, 2'd0);
        check_val("p2_red", 32'(r_hi[0]), 32'd15);
        check_val("p2_blue", 32'(b_hi[0]), 32'd0);
        check_val("p2_green", 32'(g_hi[0]), 32'd0);

        // Mid-frame switch 1->2 at cnt 5: current frame stays blue
        to_mid_frame();
        player_sel = 2'd1;
        measure(2, 4, 2'd2);
        check_val("sw_f0_blue", 32'(b_hi[0]), 32'd15);
        check_val("sw_f0_red", 32'(r_hi[0]), 32'd0);
        check_val("sw_f1_red", 32'(r_hi[1]), 32'd15);
        check_val("sw_f1_blue", 32'(b_hi[1]), 32'd0);

        // Tie -> breathing yellow, player_sel ignored
        to_mid_frame();
        tie_state = 4'h2;
        @(negedge clk);
        check_val("tie_mode", 32'(mode), 32'd3);
        measure(32, -1, 2'd0);
        for (int f = 0; f < 32; f++) begin
            check_val($sformatf("br_red%0d", f), 32'(r_hi[f]), 32'(exp_breath[f]));
            check_val($sformatf("br_grn%0d", f), 32'(g_hi[f]), 32'(exp_breath[f]));
            check_val($sformatf("br_blu%0d", f), 32'(b_hi[f]), 32'd0);
        end

        // Win with tie still set -> blink green wins
        to_mid_frame();
        win_state = 4'h1;
        @(negedge clk);
        check_val("win_tie_mode", 32'(mode), 32'd2);
        measure(6, -1, 2'd0);
        for (int f = 0; f < 6; f++) begin
            check_val($sformatf("bl_grn%0d", f), 32'(g_hi[f]), 32'(exp_blink[f]));
            check_val($sformatf("bl_red%0d", f), 32'(r_hi[f]), 32'd0);
            check_val($sformatf("bl_blu%0d", f), 32'(b_hi[f]), 32'd0);
        end

        // Reset mid-blink, then blink restarts in phase on
        reset = 1'b1;
        @(negedge clk);
        check_val("mrst_mode", 32'(mode), 32'd0);
        check_val("mrst_leds", 32'({red_LED, green_LED, blue_LED}), 32'd0);
        check_val("mrst_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rel_mode", 32'(mode), 32'd2);
        measure(3, -1, 2'd0);
        check_val("rel_grn0", 32'(g_hi[0]), 32'd15);
        check_val("rel_grn1", 32'(g_hi[1]), 32'd15);
        check_val("rel_grn2", 32'(g_hi[2]), 32'd0);
        check_val("rel_red0", 32'(r_hi[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
